// File: rtl/mem_msg_pkg.sv
// mem_msg_pkg: memory request/response encodings and byte-lane select/extend helpers
package mem_msg_pkg;
  typedef enum logic {MEM_RD = 1'b0, MEM_WR = 1'b1} mem_op_e;
  typedef enum logic [1:0] {
    MEM_LEN_W   = 2'd0,
    MEM_LEN_B   = 2'd1,
    MEM_LEN_H   = 2'd2,
    MEM_LEN_RSV = 2'd3
  } mem_len_e;
  localparam int MEM_DATA_BITS = 32;
  localparam int MEM_ADDR_BITS = 32;
  typedef logic [MEM_DATA_BITS-1:0] mem_data_t;
  typedef logic [MEM_ADDR_BITS-1:0] mem_addr_t;
  // Reserved length behaves as a full word everywhere.
  function automatic logic [4:0] lane_shift(input mem_len_e len, input logic [1:0] off);
    return len == MEM_LEN_B ? {off, 3'b000} : len == MEM_LEN_H ? {off[1], 4'b0000} : 5'd0;
  endfunction
  function automatic mem_data_t lane_mask(input mem_len_e len);
    return len == MEM_LEN_B ? 32'h0000_00ff : len == MEM_LEN_H ? 32'h0000_ffff : 32'hffff_ffff;
  endfunction
  function automatic mem_data_t wr_merge(input mem_data_t old, input mem_data_t wdata,
                                         input mem_len_e len, input logic [1:0] off);
    mem_data_t m;
    m = lane_mask(len) << lane_shift(len, off);
    return (old & ~m) | ((wdata << lane_shift(len, off)) & m);
  endfunction
  function automatic mem_data_t rd_extract(input mem_data_t word, input mem_len_e len,
                                           input logic [1:0] off);
    return (word >> lane_shift(len, off)) & lane_mask(len);
  endfunction
  function automatic logic misaligned(input mem_len_e len, input logic [1:0] off);
    return len == MEM_LEN_H ? off[0] : (len != MEM_LEN_B && off != 2'b00);
  endfunction
endpackage

// File: rtl/resp_fifo.sv
// resp_fifo: circular val/rdy FIFO with occupancy count; output data reads as zero when empty
module resp_fifo #(
  parameter int p_depth = 4,
  parameter int p_width = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         enq_val,
  output logic                         enq_rdy,
  input  logic [p_width-1:0]           enq_data,
  output logic                         deq_val,
  input  logic                         deq_rdy,
  output logic [p_width-1:0]           deq_data,
  output logic [$clog2(p_depth+1)-1:0] count
);
  localparam int AW = p_depth > 1 ? $clog2(p_depth) : 1;
  localparam int CW = $clog2(p_depth + 1);
  logic [p_width-1:0] buf_q [p_depth];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic enq, deq;
  always_comb begin
    enq_rdy  = cnt_q < CW'(p_depth);
    deq_val  = cnt_q != '0;
    enq      = enq_val && enq_rdy;
    deq      = deq_val && deq_rdy;
    wr_d     = enq ? (wr_q == AW'(p_depth - 1) ? '0 : wr_q + AW'(1)) : wr_q;
    rd_d     = deq ? (rd_q == AW'(p_depth - 1) ? '0 : rd_q + AW'(1)) : rd_q;
    cnt_d    = cnt_q + CW'(enq) - CW'(deq);
    deq_data = deq_val ? buf_q[rd_q] : '0;
    count    = cnt_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk) begin
    if (enq) buf_q[wr_q] <= enq_data;
  end
endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: word-array memory server with fixed-latency, in-order, backpressure-safe responses.
// Define MEM_RESP_ALIGN_CHK_EN to add resp_err and suppress misaligned word/halfword accesses.
module data_mem_responder
  import mem_msg_pkg::*;
#(
  parameter int p_opaq_bits = 8,
  parameter int p_mem_words = 1024,
  parameter int p_latency   = 2,
  parameter int p_depth     = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_val,
  output logic                   req_rdy,
  input  logic                   req_op,
  input  logic [p_opaq_bits-1:0] req_opaque,
  input  logic [31:0]            req_addr,
  input  logic [1:0]             req_len,
  input  logic [31:0]            req_data,
  output logic                   resp_val,
  input  logic                   resp_rdy,
  output logic                   resp_op,
  output logic [p_opaq_bits-1:0] resp_opaque,
  output logic [31:0]            resp_addr,
  output logic [1:0]             resp_len,
  output logic [31:0]            resp_data
`ifdef MEM_RESP_ALIGN_CHK_EN
  ,
  output logic                   resp_err
`endif
);
  localparam int IW = $clog2(p_mem_words);
  localparam int OW = $clog2(p_depth + 1);
  typedef struct packed {
    logic                   op;
    logic [p_opaq_bits-1:0] opaque;
    logic [31:0]            addr;
    logic [1:0]             len;
    logic [31:0]            data;
`ifdef MEM_RESP_ALIGN_CHK_EN
    logic                   err;
`endif
  } resp_t;
  localparam int RW = $bits(resp_t);
  logic [31:0] mem_q [p_mem_words];
  logic [p_latency-1:0] pv_q, pv_d;
  resp_t [p_latency-1:0] pd_q, pd_d;
  logic [OW-1:0] occ_q, occ_d, fifo_cnt;
  logic acc, wr_en, bad, fifo_enq_rdy, resp_hs;
  logic [IW-1:0] idx;
  logic [RW-1:0] fifo_out;
  mem_len_e len;
  resp_t cur, out;
  always_comb begin
    // fifo terms are invariants of the occupancy bound, kept as a guard against overflow
    req_rdy = rst_n && occ_q < OW'(p_depth) && fifo_enq_rdy && fifo_cnt <= occ_q;
    acc     = req_val && req_rdy;
    len     = mem_len_e'(req_len);
    idx     = req_addr[IW+1:2];
`ifdef MEM_RESP_ALIGN_CHK_EN
    bad     = misaligned(len, req_addr[1:0]);
`else
    bad     = 1'b0;
`endif
    wr_en   = acc && mem_op_e'(req_op) == MEM_WR && !bad;
    cur        = '0;
    cur.op     = req_op;
    cur.opaque = req_opaque;
    cur.addr   = req_addr;
    cur.len    = req_len;
    cur.data   = (mem_op_e'(req_op) == MEM_WR || bad) ? 32'd0 : rd_extract(mem_q[idx], len, req_addr[1:0]);
`ifdef MEM_RESP_ALIGN_CHK_EN
    cur.err    = bad;
`endif
    pv_d    = pv_q;
    pd_d    = pd_q;
    pv_d[0] = acc;
    pd_d[0] = cur;
    for (int i = 1; i < p_latency; i++) begin
      pv_d[i] = pv_q[i-1];
      pd_d[i] = pd_q[i-1];
    end
    resp_hs = resp_val && resp_rdy;
    occ_d   = occ_q + OW'(acc) - OW'(resp_hs);
    out         = resp_t'(fifo_out);
    resp_op     = out.op;
    resp_opaque = out.opaque;
    resp_addr   = out.addr;
    resp_len    = out.len;
    resp_data   = out.data;
`ifdef MEM_RESP_ALIGN_CHK_EN
    resp_err    = out.err;
`endif
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q <= '0;
      pv_q  <= '0;
    end else begin
      occ_q <= occ_d;
      pv_q  <= pv_d;
    end
  end
  always_ff @(posedge clk) begin
    pd_q <= pd_d;
    if (wr_en) mem_q[idx] <= wr_merge(mem_q[idx], req_data, len, req_addr[1:0]);
  end
  resp_fifo #(.p_depth(p_depth), .p_width(RW)) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .enq_val  (pv_q[p_latency-1]),
    .enq_rdy  (fifo_enq_rdy),
    .enq_data (pd_q[p_latency-1]),
    .deq_val  (resp_val),
    .deq_rdy  (resp_rdy),
    .deq_data (fifo_out),
    .count    (fifo_cnt)
  );
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: directed self-checking bench for data_mem_responder (default parameters)
module tb_data_mem_responder;
  logic clk = 1'b0, rst_n = 1'b0;
  logic req_val = 1'b0, req_rdy, req_op = 1'b0;
  logic [7:0] req_opaque = '0, resp_opaque;
  logic [31:0] req_addr = '0, req_data = '0, resp_addr, resp_data;
  logic [1:0] req_len = '0, resp_len;
  logic resp_val, resp_rdy = 1'b0, resp_op;
  logic exp_err = 1'b0;
  int checks = 0, passed = 0, waited, got, acc, stalls, first, last;
`ifdef MEM_RESP_ALIGN_CHK_EN
  logic resp_err;
`endif
  always #5 clk = ~clk;
  data_mem_responder dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_val     (req_val),
    .req_rdy     (req_rdy),
    .req_op      (req_op),
    .req_opaque  (req_opaque),
    .req_addr    (req_addr),
    .req_len     (req_len),
    .req_data    (req_data),
    .resp_val    (resp_val),
    .resp_rdy    (resp_rdy),
    .resp_op     (resp_op),
    .resp_opaque (resp_opaque),
    .resp_addr   (resp_addr),
    .resp_len    (resp_len),
    .resp_data   (resp_data)
`ifdef MEM_RESP_ALIGN_CHK_EN
    ,
    .resp_err    (resp_err)
`endif
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask
  task automatic issue(input logic op, input logic [7:0] opq, input logic [31:0] addr,
                       input logic [1:0] len, input logic [31:0] data);
    @(negedge clk);
    req_val = 1'b1;
    req_op = op;
    req_opaque = opq;
    req_addr = addr;
    req_len = len;
    req_data = data;
    chk("issue_rdy", req_rdy, 1);
  endtask
  task automatic idle();
    @(negedge clk);
    req_val = 1'b0;
  endtask
  task automatic expect_resp(input string tag, input logic op, input logic [7:0] opq,
                             input logic [31:0] addr, input logic [1:0] len, input logic [31:0] data);
    waited = 0;
    while (resp_val !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    chk({tag, "_val"}, resp_val, 1);
    chk({tag, "_opq"}, resp_opaque, opq);
    chk({tag, "_data"}, resp_data, data);
    chk({tag, "_fields"}, {resp_op, resp_addr, resp_len}, {op, addr, len});
`ifdef MEM_RESP_ALIGN_CHK_EN
    chk({tag, "_err"}, resp_err, exp_err);
`endif
    @(negedge clk);
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    resp_rdy = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_req_rdy", req_rdy, 0);
    chk("rst_resp_val", resp_val, 0);
    chk("rst_resp_fields", {resp_opaque, resp_data, resp_addr, resp_len, resp_op}, 0);
    rst_n = 1'b1;
    #1 chk("post_rst_rdy", req_rdy, 1);
    issue(1'b1, 8'h11, 32'h100, 2'd0, 32'hdeadbeef); idle();
    expect_resp("wr_word", 1'b1, 8'h11, 32'h100, 2'd0, 32'h0);
    issue(1'b0, 8'h22, 32'h100, 2'd0, 32'h0); idle();
    expect_resp("rd_word", 1'b0, 8'h22, 32'h100, 2'd0, 32'hdeadbeef);
    chk("rd_latency", waited, 2);
    issue(1'b1, 8'h30, 32'h200, 2'd0, 32'h11223344); idle();
    expect_resp("wr_base", 1'b1, 8'h30, 32'h200, 2'd0, 32'h0);
    issue(1'b1, 8'h31, 32'h201, 2'd1, 32'h000000aa); idle();
    expect_resp("wr_byte", 1'b1, 8'h31, 32'h201, 2'd1, 32'h0);
    issue(1'b0, 8'h32, 32'h200, 2'd0, 32'h0); idle();
    expect_resp("rd_merged", 1'b0, 8'h32, 32'h200, 2'd0, 32'h1122aa44);
    issue(1'b0, 8'h33, 32'h201, 2'd1, 32'h0); idle();
    expect_resp("rd_byte", 1'b0, 8'h33, 32'h201, 2'd1, 32'h000000aa);
    issue(1'b0, 8'h34, 32'h202, 2'd2, 32'h0); idle();
    expect_resp("rd_half", 1'b0, 8'h34, 32'h202, 2'd2, 32'h00001122);
    issue(1'b1, 8'h35, 32'h202, 2'd2, 32'h1234beef); idle();
    expect_resp("wr_half", 1'b1, 8'h35, 32'h202, 2'd2, 32'h0);
    issue(1'b0, 8'h36, 32'h200, 2'd3, 32'h0); idle();
    expect_resp("rd_rsv_len", 1'b0, 8'h36, 32'h200, 2'd3, 32'hbeefaa44);
    issue(1'b0, 8'h37, 32'h203, 2'd1, 32'h0); idle();
    expect_resp("rd_byte3", 1'b0, 8'h37, 32'h203, 2'd1, 32'h000000be);
    issue(1'b0, 8'h38, 32'h1100, 2'd0, 32'h0); idle();
    expect_resp("rd_alias", 1'b0, 8'h38, 32'h1100, 2'd0, 32'hdeadbeef);
`ifdef MEM_RESP_ALIGN_CHK_EN
    exp_err = 1'b1;
    issue(1'b1, 8'h60, 32'h102, 2'd0, 32'h12345678); idle();
    expect_resp("wr_misalign", 1'b1, 8'h60, 32'h102, 2'd0, 32'h0);
    issue(1'b0, 8'h61, 32'h201, 2'd2, 32'h0); idle();
    expect_resp("rd_misalign", 1'b0, 8'h61, 32'h201, 2'd2, 32'h0);
    exp_err = 1'b0;
    issue(1'b0, 8'h62, 32'h100, 2'd0, 32'h0); idle();
    expect_resp("rd_unchanged", 1'b0, 8'h62, 32'h100, 2'd0, 32'hdeadbeef);
`else
    issue(1'b0, 8'h60, 32'h102, 2'd0, 32'h0); idle();
    expect_resp("rd_truncated", 1'b0, 8'h60, 32'h102, 2'd0, 32'hdeadbeef);
`endif
    issue(1'b1, 8'h70, 32'h300, 2'd0, 32'h55667788);
    issue(1'b0, 8'h71, 32'h300, 2'd0, 32'h0); idle();
    expect_resp("b2b_wr", 1'b1, 8'h70, 32'h300, 2'd0, 32'h0);
    expect_resp("b2b_rd", 1'b0, 8'h71, 32'h300, 2'd0, 32'h55667788);
    resp_rdy = 1'b0;
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      req_val = 1'b1;
      req_op = 1'b0;
      req_addr = 32'h300;
      req_len = 2'd0;
      req_opaque = 8'(8'h40 + acc);
      if (req_rdy) acc++;
    end
    @(negedge clk);
    req_val = 1'b0;
    chk("bp_accepted", acc, 4);
    chk("bp_rdy_low", req_rdy, 0);
    chk("bp_head_opq", resp_opaque, 8'h40);
    resp_rdy = 1'b1;
    got = 0;
    for (int i = 0; i < 10; i++) begin
      if (resp_val) begin
        chk("bp_order", resp_opaque, 8'(8'h40 + got));
        got++;
      end
      @(negedge clk);
    end
    chk("bp_count", got, 4);
    chk("bp_drained", resp_val, 0);
    got = 0; stalls = 0; first = -1; last = -1;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      if (resp_val) begin
        chk("st_order", resp_opaque, 8'(got));
        if (first < 0) first = c;
        last = c;
        got++;
      end
      if (c < 16) begin
        req_val = 1'b1;
        req_op = 1'b0;
        req_addr = 32'h100;
        req_len = 2'd0;
        req_opaque = 8'(c);
        if (!req_rdy) stalls++;
      end else req_val = 1'b0;
    end
    chk("st_count", got, 16);
    chk("st_back_to_back", last - first, 15);
    chk("st_no_stall", stalls, 0);
    resp_rdy = 1'b0;
    for (int i = 0; i < 3; i++) issue(1'b0, 8'(8'h80 + i), 32'h100, 2'd0, 32'h0);
    idle();
    repeat (2) @(negedge clk);
    chk("pre_rst_val", resp_val, 1);
    rst_n = 1'b0;
    #1 chk("rst_val_drop", resp_val, 0);
    chk("rst_rdy_drop", req_rdy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    resp_rdy = 1'b1;
    #1 chk("rst2_rdy", req_rdy, 1);
    got = 0;
    repeat (6) begin
      @(negedge clk);
      if (resp_val) got++;
    end
    chk("no_stale", got, 0);
    issue(1'b0, 8'h99, 32'h100, 2'd0, 32'h0); idle();
    expect_resp("mem_kept", 1'b0, 8'h99, 32'h100, 2'd0, 32'hdeadbeef);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
